lsu_mem_ctrl: RTL and testbench

Load/store controller that sits directly upstream of the single-port data SRAM (SP_SRAM) in the RISC-V core. It accepts byte, halfword and word load/store requests at arbitrary byte addresses from the execute stage. It converts each request into one or two word-wide SRAM accesses with byte enables, realigns and sign/zero-extends load data, and returns a single-cycle response. Misaligned accesses that cross a word boundary are split into two sequential SRAM accesses.

---
 rtl/lsu_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the single-port data SRAM: byte/half/word, split misaligned accesses.
// Latency from accept edge: response in cycle 2 (single word), cycle 3 (split), cycle 1 (illegal size).
// No response back-pressure; req_ready is high only in IDLE, and requests while busy are ignored.
module lsu_mem_ctrl #(
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_csn,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_wen,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_di,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state;
    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic [7:0]  r_lanes;
    logic [31:0] r_di_hi;
    logic [31:0] lo;

    logic [7:0]  in_mask;
    logic [7:0]  in_lanes;
    logic [63:0] in_wide;

    // Address bits above the SRAM word range are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AWIDTH+2];

    assign req_ready = (state == IDLE) && rstn;

    // Byte-lane footprint and lane-aligned write data of the incoming request over two words.
    always_comb begin
        in_mask = 8'h00;
        case (req_size)
            2'b00:   in_mask = 8'h01;
            2'b01:   in_mask = 8'h03;
            default: in_mask = 8'h0F;
        endcase
        in_lanes = in_mask << req_addr[1:0];
        in_wide  = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
    end

    // Realign the two-word window by the byte offset, keep the access width, then extend.
    function automatic logic [31:0] extend(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [31:0] raw;
        sh  = pair >> {off, 3'b000};
        raw = sh[31:0];
        case (size)
            2'b00:   extend = uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   extend = uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    // Control FSM with all SRAM and response outputs registered so the SRAM sees glitch-free signals.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_lanes    <= 8'h00;
            r_di_hi    <= 32'h0;
            lo         <= 32'h0;
            mem_csn    <= 1'b1;
            mem_wen    <= 1'b1;
            mem_be     <= 4'h0;
            mem_di     <= 32'h0;
            mem_addr   <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_unsigned <= req_unsigned;
                        r_off      <= req_addr[1:0];
                        r_size     <= req_size;
                        r_lanes    <= in_lanes;
                        r_di_hi    <= in_wide[63:32];
                        if (req_size == 2'b11) begin
                            // Illegal size: answer immediately, never touch the SRAM.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state    <= ACC0;
                            mem_csn  <= 1'b0;
                            mem_wen  <= ~req_we;
                            mem_addr <= req_addr[AWIDTH+1:2];
                            mem_be   <= in_lanes[3:0];
                            mem_di   <= in_wide[31:0];
                        end
                    end
                end
                ACC0: begin
                    if (!r_we) begin
                        lo <= mem_dout;
                    end
                    if (|r_lanes[7:4]) begin
                        // Crossing into the next word; the address wraps at the top of the SRAM.
                        state    <= ACC1;
                        mem_addr <= mem_addr + 1'b1;
                        mem_be   <= r_lanes[7:4];
                        mem_di   <= r_di_hi;
                    end else begin
                        state     <= RESP;
                        mem_csn   <= 1'b1;
                        mem_wen   <= 1'b1;
                        mem_be    <= 4'h0;
                        mem_di    <= 32'h0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= r_we ? 32'h0
                                          : extend({32'h0, mem_dout}, r_off, r_size, r_unsigned);
                    end
                end
                ACC1: begin
                    // The upper word feeds the response directly instead of being held in a register.
                    state     <= RESP;
                    mem_csn   <= 1'b1;
                    mem_wen   <= 1'b1;
                    mem_be    <= 4'h0;
                    mem_di    <= 32'h0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= r_we ? 32'h0
                                      : extend({mem_dout, lo}, r_off, r_size, r_unsigned);
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: SRAM model, byte-level reference memory, response scoreboard.
// Responses are checked by an independent monitor popping an expectation queue.
// Stimulus waits on req_ready with a bounded loop.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_csn, mem_wen;
    logic [11:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_di, mem_dout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] sram [4096];
    logic        clr;
    logic [7:0]  refmem [16384];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.AWIDTH(12)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_csn(mem_csn), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_be(mem_be), .mem_di(mem_di), .mem_dout(mem_dout)
    );

    // Single-port SRAM: write at the edge closing a selected write cycle, read data always visible.
    assign mem_dout = sram[mem_addr];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) sram[i] <= 32'h0;
        end else if (!mem_csn && !mem_wen) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_di[8*i +: 8];
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Response monitor: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rstn && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
    end

    task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
        int          n;
        int          len;
        int          lane;
        logic [13:0] b;
        logic [11:0] w0, w1;
        logic [3:0]  be0, be1;
        logic [31:0] di0, di1, val, m0, m1;
        logic        split;
        exp_t        e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        // Reference: walk the bytes of the access in little-endian order.
        len = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        w0 = addr[13:2]; w1 = w0 + 12'd1;
        be0 = 4'h0; be1 = 4'h0; di0 = 32'h0; di1 = 32'h0; val = 32'h0; split = 1'b0;
        if (size != 2'b11) begin
            for (int i = 0; i < len; i++) begin
                b = addr[13:0] + 14'(i);
                lane = int'(b[1:0]);
                if (b[13:2] == w0) begin
                    be0[lane] = 1'b1;
                    di0[8*lane +: 8] = wdata[8*i +: 8];
                end else begin
                    split = 1'b1;
                    be1[lane] = 1'b1;
                    di1[8*lane +: 8] = wdata[8*i +: 8];
                end
                val[8*i +: 8] = refmem[b];
                if (we) refmem[b] = wdata[8*i +: 8];
            end
        end
        if (!uns && size == 2'b00) val = {{24{val[7]}}, val[7:0]};
        if (!uns && size == 2'b01) val = {{16{val[15]}}, val[15:0]};
        e.err   = (size == 2'b11);
        e.rdata = (we || size == 2'b11) ? 32'h0 : val;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            m0[8*i +: 8] = {8{be0[i]}};
            m1[8*i +: 8] = {8{be1[i]}};
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (size == 2'b11) begin
            chk("err_csn", {31'b0, mem_csn}, 32'd1);
            chk("err_latency", {31'b0, rsp_valid}, 32'd1);
        end else begin
            chk("acc0_csn", {31'b0, mem_csn}, 32'd0);
            chk("acc0_wen", {31'b0, mem_wen}, {31'b0, ~we});
            chk("acc0_addr", {20'b0, mem_addr}, {20'b0, w0});
            if (we) begin
                chk("acc0_be", {28'b0, mem_be}, {28'b0, be0});
                chk("acc0_di", mem_di & m0, di0);
            end
            if (split) begin
                @(negedge clk);
                chk("acc1_csn", {31'b0, mem_csn}, 32'd0);
                chk("acc1_addr", {20'b0, mem_addr}, {20'b0, w1});
                if (we) begin
                    chk("acc1_be", {28'b0, mem_be}, {28'b0, be1});
                    chk("acc1_di", mem_di & m1, di1);
                end
            end
            @(negedge clk);
            chk("rsp_latency", {31'b0, rsp_valid}, 32'd1);
            chk("resp_csn", {31'b0, mem_csn}, 32'd1);
        end
        @(negedge clk);
        chk("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] old4, a;
        logic [1:0]  sz;
        int          r;
        rstn = 1'b0; clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        for (int i = 0; i < 16384; i++) refmem[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("rst_csn", {31'b0, mem_csn}, 32'd1);
        chk("rst_wen", {31'b0, mem_wen}, 32'd1);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_di", mem_di, 32'd0);
        chk("rst_addr", {20'b0, mem_addr}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        // A request offered during reset must not be taken.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h12345678;
        @(negedge clk);
        chk("rst_no_accept", {31'b0, mem_csn}, 32'd1);
        req_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_csn", {31'b0, mem_csn}, 32'd1);

        xact(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        xact(1'b0, 32'h13, 2'b00, 1'b0, 32'h0);
        xact(1'b0, 32'h13, 2'b00, 1'b1, 32'h0);
        xact(1'b0, 32'h12, 2'b01, 1'b0, 32'h0);
        xact(1'b0, 32'h10, 2'b01, 1'b1, 32'h0);
        xact(1'b1, 32'h0E, 2'b10, 1'b0, 32'h11223344);
        xact(1'b0, 32'h0E, 2'b10, 1'b0, 32'h0);
        xact(1'b0, 32'h20, 2'b11, 1'b0, 32'h0);
        xact(1'b1, 32'h3FFE, 2'b10, 1'b0, 32'hCAFEF00D);
        xact(1'b0, 32'h3FFE, 2'b10, 1'b0, 32'h0);

        // Reset on the edge that would move a split store into its second word.
        old4 = sram[4];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0E; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'hA5B6C7D8;
        r = 0;
        while (!req_ready && r < 50) begin
            @(negedge clk);
            r++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("abort_csn", {31'b0, mem_csn}, 32'd1);
        chk("abort_idle", {31'b0, req_ready}, 32'd1);
        chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        refmem[14] = 8'hD8;
        refmem[15] = 8'hC7;
        chk("abort_word3", sram[3], {refmem[15], refmem[14], refmem[13], refmem[12]});
        chk("abort_word4", sram[4], old4);
        xact(1'b0, 32'h0C, 2'b10, 1'b0, 32'h0);
        xact(1'b0, 32'h10, 2'b10, 1'b0, 32'h0);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) a = 32'h3FFC + $urandom_range(0, 3);
            else                            a = $urandom_range(0, 63);
            a = a | ($urandom & 32'hFFFF_C000);
            r  = $urandom_range(0, 9);
            sz = (r == 9) ? 2'b11 : 2'(r % 3);
            xact(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
